// File: rtl/rvfi_commit_pkg.sv
// Shared types for the RVFI commit buffer: alloc/completion/packet structs and entry state.
// Optional X-scrub of don't-care packet fields is enabled by defining RVFI_X_SCRUB_EN.
package rvfi_commit_pkg;

    localparam int ORDER_W = 64;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        ALLOC = 2'd1,
        DONE  = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } rvfi_alloc_t;

    typedef struct packed {
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_cmpl_t;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_pkt_t;

    function automatic rvfi_pkt_t merge_pkt(input rvfi_alloc_t a, input rvfi_cmpl_t c);
        rvfi_pkt_t p;
        p.pc_rdata  = a.pc_rdata;
        p.inst      = a.inst;
        p.rs1_addr  = a.rs1_addr;
        p.rs2_addr  = a.rs2_addr;
        p.rd_addr   = a.rd_addr;
        p.rs1_rdata = c.rs1_rdata;
        p.rs2_rdata = c.rs2_rdata;
        p.rd_wdata  = c.rd_wdata;
        p.pc_wdata  = c.pc_wdata;
        p.mem_addr  = c.mem_addr;
        p.mem_rmask = c.mem_rmask;
        p.mem_wmask = c.mem_wmask;
        p.mem_rdata = c.mem_rdata;
        p.mem_wdata = c.mem_wdata;
        return p;
    endfunction

endpackage

// File: rtl/rvfi_commit_scrub.sv
// Combinational scrub of don't-care RVFI fields (x0 operands, unmasked byte lanes, unused address).
// Only instantiated by rvfi_commit_buffer when RVFI_X_SCRUB_EN is defined.
module rvfi_commit_scrub
    import rvfi_commit_pkg::*;
(
    input  rvfi_pkt_t i_pkt,
    output rvfi_pkt_t o_pkt
);

    logic [31:0] w_rbyte_en;
    logic [31:0] w_wbyte_en;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_rbyte_en[gi*8 +: 8] = {8{i_pkt.mem_rmask[gi]}};
        assign w_wbyte_en[gi*8 +: 8] = {8{i_pkt.mem_wmask[gi]}};
    end

    always_comb begin
        o_pkt           = i_pkt;
        o_pkt.mem_rdata = i_pkt.mem_rdata & w_rbyte_en;
        o_pkt.mem_wdata = i_pkt.mem_wdata & w_wbyte_en;
        if (i_pkt.rs1_addr == 5'd0) o_pkt.rs1_rdata = '0;
        if (i_pkt.rs2_addr == 5'd0) o_pkt.rs2_rdata = '0;
        if (i_pkt.rd_addr  == 5'd0) o_pkt.rd_wdata  = '0;
        if ((i_pkt.mem_rmask == 4'd0) && (i_pkt.mem_wmask == 4'd0)) o_pkt.mem_addr = '0;
    end

endmodule

// File: rtl/rvfi_commit_buffer.sv
// In-order RVFI commit buffer: allocate in program order, complete by tag, retire one per cycle.
// Define RVFI_X_SCRUB_EN to zero don't-care packet fields at commit.
module rvfi_commit_buffer
    import rvfi_commit_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    localparam int TAG_W       = $clog2(NUM_ENTRIES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  rvfi_alloc_t        alloc_data,
    output logic [TAG_W-1:0]   alloc_tag,
    input  logic               cmpl_valid,
    input  logic [TAG_W-1:0]   cmpl_tag,
    input  rvfi_cmpl_t         cmpl_data,
    input  logic               flush,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output rvfi_pkt_t          rvfi_pkt,
    output logic               cmpl_err
);

    logic [TAG_W:0]     r_head;
    logic [TAG_W:0]     r_tail;
    logic [ORDER_W-1:0] r_order;
    logic               r_rvfi_valid;
    logic [ORDER_W-1:0] r_rvfi_order;
    rvfi_pkt_t          r_rvfi_pkt;
    logic               r_cmpl_err;

    rvfi_alloc_t        r_alloc_mem [NUM_ENTRIES];
    rvfi_cmpl_t         r_cmpl_mem  [NUM_ENTRIES];
    entry_state_e       w_state     [NUM_ENTRIES];

    logic [TAG_W-1:0]   w_head_idx;
    logic [TAG_W-1:0]   w_tail_idx;
    logic               w_full;
    logic               w_alloc;
    logic               w_commit;
    logic               w_cmpl_hit;
    logic               w_cmpl_ok;
    logic               w_cmpl_bad;
    rvfi_pkt_t          w_pkt_merged;
    rvfi_pkt_t          w_pkt_out;

    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];
    assign w_full     = (r_head[TAG_W] != r_tail[TAG_W]) && (w_head_idx == w_tail_idx);

    // Every handshake decision looks only at registered state, so a same-cycle commit never frees room.
    assign w_alloc    = alloc_valid && !w_full && !flush;
    assign w_commit   = (w_state[w_head_idx] == DONE) && !flush;
    assign w_cmpl_hit = cmpl_valid && !flush;
    assign w_cmpl_ok  = w_cmpl_hit && (w_state[cmpl_tag] == ALLOC);
    assign w_cmpl_bad = w_cmpl_hit && (w_state[cmpl_tag] != ALLOC);

    assign alloc_ready = !w_full;
    assign alloc_tag   = w_tail_idx;

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        localparam logic [TAG_W-1:0] IDX = TAG_W'(gi);
        entry_state_e r_st;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_st <= FREE;
            end else if (flush) begin
                r_st <= FREE;
            end else if (w_alloc && (w_tail_idx == IDX)) begin
                r_st <= ALLOC;
            end else if (w_cmpl_ok && (cmpl_tag == IDX)) begin
                r_st <= DONE;
            end else if (w_commit && (w_head_idx == IDX)) begin
                r_st <= FREE;
            end
        end

        assign w_state[gi] = r_st;
    end

    // Payload storage carries no reset; an entry's fields are only read after both writes landed.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_alloc_mem[w_tail_idx] <= alloc_data;
        end
        if (w_cmpl_ok) begin
            r_cmpl_mem[cmpl_tag] <= cmpl_data;
        end
    end

    assign w_pkt_merged = merge_pkt(r_alloc_mem[w_head_idx], r_cmpl_mem[w_head_idx]);

`ifdef RVFI_X_SCRUB_EN
    rvfi_commit_scrub u_scrub (
        .i_pkt (w_pkt_merged),
        .o_pkt (w_pkt_out)
    );
`else
    assign w_pkt_out = w_pkt_merged;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_order      <= '0;
            r_rvfi_valid <= 1'b0;
            r_rvfi_order <= '0;
            r_rvfi_pkt   <= '0;
            r_cmpl_err   <= 1'b0;
        end else begin
            r_rvfi_valid <= w_commit;
            if (flush) begin
                r_head <= r_tail;
            end else begin
                if (w_commit) r_head <= r_head + (TAG_W+1)'(1);
                if (w_alloc)  r_tail <= r_tail + (TAG_W+1)'(1);
            end
            if (w_commit) begin
                r_rvfi_pkt   <= w_pkt_out;
                r_rvfi_order <= r_order;
                r_order      <= r_order + ORDER_W'(1);
            end
            if (w_cmpl_bad) begin
                r_cmpl_err <= 1'b1;
            end
        end
    end

    assign rvfi_valid = r_rvfi_valid;
    assign rvfi_order = r_rvfi_order;
    assign rvfi_pkt   = r_rvfi_pkt;
    assign cmpl_err   = r_cmpl_err;

endmodule

// File: tb/tb_rvfi_commit_buffer.sv
// Scoreboard bench for rvfi_commit_buffer: directed stimulus pushes expected commits,
// a monitor pops and compares each rvfi_valid pulse.
module tb_rvfi_commit_buffer;
    import rvfi_commit_pkg::*;

    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    rvfi_alloc_t   alloc_data = '0;
    logic [TW-1:0] alloc_tag;
    logic          cmpl_valid = 1'b0;
    logic [TW-1:0] cmpl_tag = '0;
    rvfi_cmpl_t    cmpl_data = '0;
    logic          flush = 1'b0;
    logic          rvfi_valid;
    logic [63:0]   rvfi_order;
    rvfi_pkt_t     rvfi_pkt;
    logic          cmpl_err;

    rvfi_commit_buffer #(.NUM_ENTRIES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_data  (alloc_data),
        .alloc_tag   (alloc_tag),
        .cmpl_valid  (cmpl_valid),
        .cmpl_tag    (cmpl_tag),
        .cmpl_data   (cmpl_data),
        .flush       (flush),
        .rvfi_valid  (rvfi_valid),
        .rvfi_order  (rvfi_order),
        .rvfi_pkt    (rvfi_pkt),
        .cmpl_err    (cmpl_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] order;
        rvfi_pkt_t   pkt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one line per observed commit, compared against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rvfi_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit actual order=%0d pc=%h required none", rvfi_order, rvfi_pkt.pc_rdata);
            end else begin
                e = exp_q.pop_front();
                $display("commit order=%0d pc=%h cyc=%0d", rvfi_order, rvfi_pkt.pc_rdata, cyc);
                chk("rvfi_order", rvfi_order, e.order);
                chk("rvfi_pkt", rvfi_pkt, e.pkt);
                if (e.cyc >= 0) chk("commit_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic rvfi_pkt_t mk_pkt(input rvfi_alloc_t a, input rvfi_cmpl_t c);
        rvfi_pkt_t p;
        p = '0;
        p.pc_rdata  = a.pc_rdata;
        p.inst      = a.inst;
        p.rs1_addr  = a.rs1_addr;
        p.rs2_addr  = a.rs2_addr;
        p.rd_addr   = a.rd_addr;
        p.rs1_rdata = c.rs1_rdata;
        p.rs2_rdata = c.rs2_rdata;
        p.rd_wdata  = c.rd_wdata;
        p.pc_wdata  = c.pc_wdata;
        p.mem_addr  = c.mem_addr;
        p.mem_rmask = c.mem_rmask;
        p.mem_wmask = c.mem_wmask;
        p.mem_rdata = c.mem_rdata;
        p.mem_wdata = c.mem_wdata;
        return p;
    endfunction

    function automatic rvfi_alloc_t mk_alloc(input int i);
        rvfi_alloc_t a;
        a.pc_rdata = 32'h0000_1000 + 32'(i * 4);
        a.inst     = 32'h0000_0013 | 32'(i << 7);
        a.rs1_addr = 5'((i % 30) + 1);
        a.rs2_addr = 5'((i % 29) + 2);
        a.rd_addr  = 5'((i % 31) + 1);
        return a;
    endfunction

    function automatic rvfi_cmpl_t mk_cmpl(input int i);
        rvfi_cmpl_t c;
        c.rs1_rdata = 32'hA000_0000 + 32'(i);
        c.rs2_rdata = 32'hB000_0000 + 32'(i);
        c.rd_wdata  = 32'hC000_0000 + 32'(i);
        c.pc_wdata  = 32'h0000_1004 + 32'(i * 4);
        c.mem_addr  = 32'h0000_2000 + 32'(i * 4);
        c.mem_rmask = 4'hF;
        c.mem_wmask = 4'hF;
        c.mem_rdata = 32'hD000_0000 + 32'(i);
        c.mem_wdata = 32'hE000_0000 + 32'(i);
        return c;
    endfunction

    task automatic push_exp(input logic [63:0] order, input rvfi_pkt_t p, input int at_cyc);
        exp_t e;
        e.order = order;
        e.pkt   = p;
        e.cyc   = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        cmpl_valid = 1'b0;
        flush = 1'b0;
        alloc_data = '0;
        cmpl_data = '0;
        cmpl_tag = '0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic do_alloc(input rvfi_alloc_t a, input int tag);
        alloc_valid = 1'b1;
        alloc_data  = a;
        chk("alloc_ready", alloc_ready, 1);
        chk("alloc_tag", alloc_tag, tag);
        @(negedge clk);
        alloc_valid = 1'b0;
    endtask

    task automatic do_cmpl(input int tag, input rvfi_cmpl_t c);
        cmpl_valid = 1'b1;
        cmpl_tag   = TW'(tag);
        cmpl_data  = c;
        @(negedge clk);
        cmpl_valid = 1'b0;
    endtask

    initial begin
        rvfi_alloc_t a;
        rvfi_cmpl_t  c;
        rvfi_pkt_t   p;

        // Reset state, sampled while reset is held.
        idle(3);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_rvfi_valid", rvfi_valid, 0);
        chk("rst_rvfi_order", rvfi_order, 0);
        chk("rst_rvfi_pkt", rvfi_pkt, 0);
        chk("rst_cmpl_err", cmpl_err, 0);
        rst_n = 1'b1;
        idle(1);

        // Single op, completion-to-commit latency of two cycles.
        a = '0;
        a.pc_rdata = 32'h1eceb000;
        a.inst     = 32'h00100093;
        a.rd_addr  = 5'd1;
        c = '0;
        c.rd_wdata = 32'd1;
        do_alloc(a, 0);
        push_exp(64'd0, mk_pkt(a, c), cyc + 2);
        do_cmpl(0, c);
        idle(4);

        // Out-of-order completion, in-order retirement on consecutive cycles.
        do_reset();
        for (int i = 0; i < 3; i++) do_alloc(mk_alloc(i), i);
        do_cmpl(2, mk_cmpl(2));
        do_cmpl(1, mk_cmpl(1));
        idle(3);
        push_exp(64'd0, mk_pkt(mk_alloc(0), mk_cmpl(0)), cyc + 2);
        push_exp(64'd1, mk_pkt(mk_alloc(1), mk_cmpl(1)), cyc + 3);
        push_exp(64'd2, mk_pkt(mk_alloc(2), mk_cmpl(2)), cyc + 4);
        do_cmpl(0, mk_cmpl(0));
        idle(5);

        // Full buffer: ready returns only after the commit cycle, new entry reuses tag 0.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(mk_alloc(i), i);
        chk("full_ready", alloc_ready, 0);
        push_exp(64'd0, mk_pkt(mk_alloc(0), mk_cmpl(0)), cyc + 2);
        cmpl_valid  = 1'b1;
        cmpl_tag    = 3'd0;
        cmpl_data   = mk_cmpl(0);
        alloc_valid = 1'b1;
        alloc_data  = mk_alloc(8);
        @(negedge clk);
        cmpl_valid = 1'b0;
        chk("full_ready_commit_cycle", alloc_ready, 0);
        @(negedge clk);
        chk("full_ready_after_commit", alloc_ready, 1);
        chk("full_wrap_tag", alloc_tag, 0);
        @(negedge clk);
        alloc_valid = 1'b0;
        chk("full_ready_refilled", alloc_ready, 0);
        idle(2);

        // Reset mid-operation discards the full buffer.
        do_reset();
        chk("midrst_alloc_ready", alloc_ready, 1);
        chk("midrst_alloc_tag", alloc_tag, 0);

        // Illegal completions: FREE tag, then a repeat on a DONE tag.
        chk("err_clear", cmpl_err, 0);
        do_cmpl(5, mk_cmpl(5));
        chk("err_free_tag", cmpl_err, 1);
        idle(3);
        chk("err_sticky", cmpl_err, 1);
        do_alloc(mk_alloc(10), 0);
        do_alloc(mk_alloc(11), 1);
        do_cmpl(1, mk_cmpl(11));
        do_cmpl(1, mk_cmpl(20));
        push_exp(64'd0, mk_pkt(mk_alloc(10), mk_cmpl(10)), cyc + 2);
        push_exp(64'd1, mk_pkt(mk_alloc(11), mk_cmpl(11)), cyc + 3);
        do_cmpl(0, mk_cmpl(10));
        idle(4);
        chk("err_still_set", cmpl_err, 1);

        // Flush: drops in-flight entries, suppresses alloc and completion, order continues.
        do_reset();
        do_alloc(mk_alloc(30), 0);
        push_exp(64'd0, mk_pkt(mk_alloc(30), mk_cmpl(30)), cyc + 2);
        do_cmpl(0, mk_cmpl(30));
        idle(3);
        for (int i = 1; i < 5; i++) do_alloc(mk_alloc(30 + i), i);
        do_cmpl(2, mk_cmpl(32));
        do_cmpl(3, mk_cmpl(33));
        flush       = 1'b1;
        cmpl_valid  = 1'b1;
        cmpl_tag    = 3'd3;
        cmpl_data   = mk_cmpl(99);
        alloc_valid = 1'b1;
        alloc_data  = mk_alloc(40);
        @(negedge clk);
        flush = 1'b0;
        cmpl_valid = 1'b0;
        alloc_valid = 1'b0;
        chk("flush_no_err", cmpl_err, 0);
        chk("flush_ready", alloc_ready, 1);
        idle(3);
        do_alloc(mk_alloc(41), 5);
        push_exp(64'd1, mk_pkt(mk_alloc(41), mk_cmpl(41)), cyc + 2);
        do_cmpl(5, mk_cmpl(41));
        idle(4);

        // Don't-care fields: scrubbed when the feature is built in, untouched otherwise.
        do_reset();
        a = mk_alloc(50);
        a.rs1_addr = 5'd0;
        a.rs2_addr = 5'd2;
        a.rd_addr  = 5'd0;
        c = mk_cmpl(50);
        c.rs1_rdata = 32'h1111_1111;
        c.rd_wdata  = 32'hDEAD_DEAD;
        c.mem_addr  = 32'h8000_1004;
        c.mem_rmask = 4'b0000;
        c.mem_wmask = 4'b0011;
        c.mem_rdata = 32'hCAFE_F00D;
        c.mem_wdata = 32'h1234_BEEF;
        p = mk_pkt(a, c);
`ifdef RVFI_X_SCRUB_EN
        p.rs1_rdata = 32'h0;
        p.rd_wdata  = 32'h0;
        p.mem_rdata = 32'h0;
        p.mem_wdata = 32'h0000_BEEF;
`endif
        do_alloc(a, 0);
        push_exp(64'd0, p, cyc + 2);
        do_cmpl(0, c);
        idle(3);
        a = mk_alloc(51);
        c = mk_cmpl(51);
        c.mem_addr  = 32'h8000_1008;
        c.mem_rmask = 4'b0000;
        c.mem_wmask = 4'b0000;
        p = mk_pkt(a, c);
`ifdef RVFI_X_SCRUB_EN
        p.mem_addr  = 32'h0;
        p.mem_rdata = 32'h0;
        p.mem_wdata = 32'h0;
`endif
        do_alloc(a, 1);
        push_exp(64'd1, p, cyc + 2);
        do_cmpl(1, c);
        idle(5);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
